fpu_op_sequencer: RTL and testbench
===================================

Name: fpu_op_sequencer

Overview:
- Operand feeder and result collector placed directly upstream of the fpu adder.
- Accepts operand pairs through a valid/ready handshake into a small FIFO and presents one pair at a time, held stable, to the fpu.
- Drives the fpu's active-low reset so each operation starts deterministically, waits a fixed worst-case window, then captures fpu data/status.
- Returns the captured result through a valid/ready handshake and keeps sticky status flags and an operation counter.

Parameters:
- DEPTH, 4: operand FIFO entries; power of 2, minimum 2.
- WAIT_CYCLES, 72: clock edges from fpu reset release to result capture; minimum 70, the fpu worst case being a full-cancellation path of 69 edges.
- CNT_W, 16: op_count width.

Ports:
- clock100KHz  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO not full.
- in_op_a  in  32  operand A: sign, exp[5:0], mant[24:0].
- in_op_b  in  32  operand B, same format.
- fpu_op_a  out  32  to fpu op_A_in.
- fpu_op_b  out  32  to fpu op_B_in.
- fpu_reset_n  out  1  to fpu reset (active-low).
- fpu_data_in  in  32  from fpu data_out.
- fpu_status_in  in  4  from fpu status_out.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  32  captured result.
- res_status  out  4  captured status {UNDERFLOW, OVERFLOW, INEXACT, EXACT}.
- sticky_status  out  4  OR of all captured statuses since last clear.
- sticky_clear  in  1  synchronous clear of sticky_status.
- busy  out  1  high in every state except IDLE.
- op_count  out  CNT_W  completed captures; wraps to 0.

Behaviour:
- Reset values while reset=1:
  - FIFO empty; state IDLE.
  - fpu_op_a, fpu_op_b, res_data, res_status, sticky_status, op_count all 0.
  - fpu_reset_n=0, res_valid=0, busy=0, in_ready=1 once the FIFO is empty.
- A reset asserted mid-operation discards the FIFO contents and any in-flight op; no res_valid is produced for them.
- Push happens when in_valid&&in_ready at the clock edge. in_ready = !full, driven combinationally from the FIFO count.
- Push and pop on the same edge leave the count unchanged. No push is possible while full.
- All outputs except in_ready are registered.
- States:
  - IDLE: if the FIFO is non-empty, pop the head into fpu_op_a/fpu_op_b and go to RST.
  - RST: one cycle with fpu_reset_n=0; go to WAIT and clear the counter.
  - WAIT: fpu_reset_n=1; the counter increments each edge.
    - On the edge where counter==WAIT_CYCLES-1: res_data<=fpu_data_in, res_status<=fpu_status_in, res_valid<=1, sticky_status<=sticky_status|fpu_status_in, op_count<=op_count+1. Go to OUT.
  - OUT: fpu_reset_n=0. Hold res_* stable. On res_valid&&res_ready, clear res_valid and go to IDLE.
- fpu_reset_n=0 in IDLE, RST and OUT, so the fpu sits idle at zero outputs between operations.
- fpu_op_a/fpu_op_b stay constant from the RST edge through the end of OUT.
- Latency: push accepted at edge E0 with the block IDLE and the FIFO empty gives res_valid high after edge E0+WAIT_CYCLES+2 (74 at default).
- Throughput: one op per WAIT_CYCLES+3 edges when res_ready is held high.
- sticky_clear:
  - sticky_clear alone gives sticky_status<=0 on the next edge.
  - sticky_clear coinciding with a capture gives sticky_status<=fpu_status_in; the clear happens first and the new status is kept.
- op_count wraps from all-ones to 0 with no flag.
- in_valid while the block is busy only fills the FIFO. FIFO order is strictly preserved.

Decomposition:
- fpu_pkg holds:
  - status constants EXACT=4'b0001, INEXACT=4'b0010, OVERFLOW=4'b0100, UNDERFLOW=4'b1000;
  - the seq_state_t enum {IDLE, RST, WAIT, OUT};
  - the field widths SIGN=1, EXP_W=6, MANT_W=25.
- One sub-module, fpu_op_fifo: a synchronous FIFO with a 64-bit payload, DEPTH entries, pointers carrying one extra wrap bit, and full/empty/count outputs.
- The FSM, counter, and result/sticky registers live in fpu_op_sequencer.

Test Plan:
- Idle, push A=0x40000000, B=0x40000000, res_ready=1 -> res_valid exactly 74 edges after the push; res_data=0x42000000, res_status=4'b0001; op_count=1; busy falls the cycle after the handshake.
- Push A=0x40000000, B=0xC0000000 (full cancellation, fpu worst-case path) -> res_data=0x00000000, res_status=4'b0001; captures are stable across WAIT_CYCLES=70 and 72.
- res_ready=0 with in_valid held high and distinct operands -> exactly 5 pairs accepted (1 in flight + DEPTH), in_ready=0 afterwards. Releasing res_ready then drains the results in push order, and in_ready returns 1 the cycle after the first pop.
- A result with status 4'b0010, then sticky_clear pulsed on the capture edge of a second op whose status is 4'b0001 -> sticky_status=4'b0001 (not 4'b0011).
- reset pulsed mid-WAIT with 2 entries queued -> all outputs at reset values the same cycle, no res_valid ever for the discarded ops, in_ready=1, and a new push afterwards completes normally in 74 edges.
- Preload op_count to 0xFFFF via 65535 ops (or force) then one more op -> op_count=0x0000.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and constants for the fpu operand sequencer.
// Operand layout is {sign, exp[5:0], mant[24:0]}; status is one-hot per outcome.
package fpu_pkg;

  localparam int SIGN   = 1;
  localparam int EXP_W  = 6;
  localparam int MANT_W = 25;
  localparam int OP_W   = SIGN + EXP_W + MANT_W;

  typedef logic [3:0] status_t;

  localparam status_t EXACT     = 4'b0001;
  localparam status_t INEXACT   = 4'b0010;
  localparam status_t OVERFLOW  = 4'b0100;
  localparam status_t UNDERFLOW = 4'b1000;

  typedef enum logic [1:0] {IDLE, RST, WAIT, OUT} seq_state_t;

endpackage

// File: rtl/fpu_op_fifo.sv
// Synchronous operand FIFO with wrap-bit pointers; full/empty derived from the pointers.
module fpu_op_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)  wptr <= wptr + 1'b1;
      if (pop  && !empty) rptr <= rptr + 1'b1;
    end
  end

  // Payload storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/fpu_op_sequencer.sv
// Feeds queued operand pairs to the fpu one at a time, resetting it per operation,
// and captures its result after a fixed worst-case settling window.
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int WAIT_CYCLES = 72,
  parameter int CNT_W       = 16
) (
  input  logic             clock100KHz,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op_a,
  input  logic [OP_W-1:0]  in_op_b,
  output logic [OP_W-1:0]  fpu_op_a,
  output logic [OP_W-1:0]  fpu_op_b,
  output logic             fpu_reset_n,
  input  logic [OP_W-1:0]  fpu_data_in,
  input  logic [3:0]       fpu_status_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OP_W-1:0]  res_data,
  output logic [3:0]       res_status,
  output logic [3:0]       sticky_status,
  input  logic             sticky_clear,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(WAIT_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(WAIT_CYCLES - 1);

  seq_state_t          state;
  logic [TW-1:0]       timer;
  logic [2*OP_W-1:0]   head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fill_count;
  logic                push;
  logic                pop;
  logic                capture;

  assign in_ready = (fill_count != CW'(DEPTH));
  assign push     = in_valid && !fifo_full;
  assign pop      = (state == IDLE) && !fifo_empty;
  assign capture  = (state == WAIT) && (timer == LAST);

  fpu_op_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (2*OP_W)
  ) u_fifo (
    .clk   (clock100KHz),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({in_op_a, in_op_b}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fill_count)
  );

  always_ff @(posedge clock100KHz or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      fpu_op_a      <= '0;
      fpu_op_b      <= '0;
      fpu_reset_n   <= 1'b0;
      res_valid     <= 1'b0;
      res_data      <= '0;
      res_status    <= '0;
      sticky_status <= '0;
      op_count      <= '0;
      busy          <= 1'b0;
    end else begin
      // A clear landing on a capture edge keeps only the freshly captured status.
      if (sticky_clear)  sticky_status <= capture ? fpu_status_in : 4'b0000;
      else if (capture)  sticky_status <= sticky_status | fpu_status_in;

      case (state)
        IDLE: if (pop) begin
          fpu_op_a <= head[2*OP_W-1 -: OP_W];
          fpu_op_b <= head[OP_W-1:0];
          busy     <= 1'b1;
          state    <= RST;
        end
        RST: begin
          fpu_reset_n <= 1'b1;
          timer       <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (capture) begin
            res_data    <= fpu_data_in;
            res_status  <= fpu_status_in;
            res_valid   <= 1'b1;
            op_count    <= op_count + 1'b1;
            fpu_reset_n <= 1'b0;
            state       <= OUT;
          end
        end
        OUT: if (res_valid && res_ready) begin
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Scoreboard bench for fpu_op_sequencer with a behavioural fpu stand-in.
module tb_fpu_op_sequencer;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic        sticky_clear = 1'b0;
  logic [31:0] in_op_a = '0;
  logic [31:0] in_op_b = '0;
  logic        in_ready, fpu_reset_n, res_valid, busy;
  logic [31:0] fpu_op_a, fpu_op_b, fpu_data_in, res_data;
  logic [3:0]  fpu_status_in, res_status, sticky_status;
  logic [15:0] op_count;

  int errors = 0;
  int checks = 0;
  logic [35:0] sb[$];

  logic [31:0] fill_a [5] = '{32'h42000000, 32'h44000000, 32'h46000000, 32'h48000000, 32'h4A000000};
  logic [31:0] fill_r [5] = '{32'h44000000, 32'h46000000, 32'h48000000, 32'h4A000000, 32'h4C000000};

  always #5 clk = ~clk;

  fpu_op_sequencer dut (
    .clock100KHz   (clk),
    .reset         (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op_a       (in_op_a),
    .in_op_b       (in_op_b),
    .fpu_op_a      (fpu_op_a),
    .fpu_op_b      (fpu_op_b),
    .fpu_reset_n   (fpu_reset_n),
    .fpu_data_in   (fpu_data_in),
    .fpu_status_in (fpu_status_in),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_status    (res_status),
    .sticky_status (sticky_status),
    .sticky_clear  (sticky_clear),
    .busy          (busy),
    .op_count      (op_count)
  );

  // fpu stand-in: zero while held in reset, garbage until its latency elapses.
  int          stub_cnt = 0;
  logic [31:0] stub_d;
  logic [3:0]  stub_s;
  int          stub_lat;

  always @(posedge clk) stub_cnt <= fpu_reset_n ? stub_cnt + 1 : 0;

  always_comb begin
    stub_d   = 32'h0;
    stub_s   = UNDERFLOW;
    stub_lat = 30;
    if (fpu_op_a == 32'h40000000 && fpu_op_b == 32'hC0000000) begin
      stub_d = 32'h0; stub_s = EXACT; stub_lat = 69;
    end else if (fpu_op_a == 32'h3F000001 && fpu_op_b == 32'h40000000) begin
      stub_d = 32'h40800000; stub_s = INEXACT; stub_lat = 40;
    end else if (fpu_op_a == fpu_op_b) begin
      stub_d = fpu_op_a + 32'h02000000; stub_s = EXACT;
    end
    if (!fpu_reset_n) begin
      fpu_data_in = 32'h0; fpu_status_in = 4'b0000;
    end else if (stub_cnt >= stub_lat) begin
      fpu_data_in = stub_d; fpu_status_in = stub_s;
    end else begin
      fpu_data_in = 32'hDEADBEEF; fpu_status_in = 4'b1111;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every result handshake is checked against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h/%b with nothing expected", res_data, res_status);
      end else begin
        chk("result", {res_data, res_status}, sb.pop_front());
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [35:0] e);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_op_a = a; in_op_b = b;
    while (!in_ready && n < 500) begin @(negedge clk); n++; end
    if (!in_ready) chk("push_timeout", {63'b0, in_ready}, 64'd1);
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!res_valid && n < 300);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    int seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ops", {fpu_op_a, fpu_op_b}, 64'd0);
    chk("rst_res", {res_data, res_status, sticky_status, op_count}, 64'd0);
    chk("rst_ctrl", {fpu_reset_n, res_valid, busy, in_ready}, 64'b0001);
    rst = 1'b0;
    res_ready = 1'b1;

    // Basic add: latency, count, busy release after handshake.
    push(32'h40000000, 32'h40000000, {32'h42000000, EXACT});
    wait_res(n);
    chk("lat_add", n, 74);
    chk("out_state", {busy, fpu_reset_n, op_count}, {1'b1, 1'b0, 16'd1});
    chk("ops_held", {fpu_op_a, fpu_op_b}, {32'h40000000, 32'h40000000});
    @(posedge clk); #1;
    chk("post_hs", {busy, res_valid}, 2'b00);

    // Full cancellation, slowest fpu path.
    push(32'h40000000, 32'hC0000000, {32'h00000000, EXACT});
    wait_res(n);
    chk("lat_cancel", n, 74);
    chk("cnt2", op_count, 16'd2);
    @(posedge clk); #1;

    // Back-pressure: in_valid held with res_ready low fills 1 + DEPTH.
    res_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_op_a  = (k < 5) ? fill_a[k] : 32'h0;
      in_op_b  = (k < 5) ? fill_a[k] : 32'h0;
      if (in_ready) begin
        sb.push_back((k < 5) ? {fill_r[k], EXACT} : 36'h0);
        k++;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("fill_accepted", k, 5);
    chk("fill_full", in_ready, 1'b0);
    res_ready = 1'b1;
    wait_res(n);
    @(posedge clk); #1;
    chk("ready_at_hs", in_ready, 1'b0);
    @(posedge clk); #1;
    chk("ready_after_pop", in_ready, 1'b1);
    n = 0;
    while (sb.size() != 0 && n < 2000) begin @(posedge clk); n++; end
    chk("drain", sb.size(), 0);
    chk("cnt7", op_count, 16'd7);
    repeat (2) @(posedge clk);

    // Sticky behaviour.
    @(negedge clk); sticky_clear = 1'b1;
    @(negedge clk); sticky_clear = 1'b0;
    chk("clr_alone", sticky_status, 4'b0000);
    push(32'h3F000001, 32'h40000000, {32'h40800000, INEXACT});
    wait_res(n);
    chk("sticky_inexact", sticky_status, 4'b0010);
    @(posedge clk); #1;
    push(32'h40000000, 32'h40000000, {32'h42000000, EXACT});
    repeat (73) @(posedge clk);
    @(negedge clk); sticky_clear = 1'b1;
    @(posedge clk); #1;
    sticky_clear = 1'b0;
    chk("clear_on_capture", {res_valid, sticky_status}, {1'b1, 4'b0001});
    @(posedge clk); #1;

    // Reset mid-WAIT with two entries queued.
    push(32'h40000000, 32'h40000000, {32'h42000000, EXACT});
    push(32'h40000000, 32'hC0000000, {32'h00000000, EXACT});
    push(32'h3F000001, 32'h40000000, {32'h40800000, INEXACT});
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    sb.delete();
    chk("midrst_ops", {fpu_op_a, fpu_op_b}, 64'd0);
    chk("midrst_res", {res_data, res_status, sticky_status, op_count}, 64'd0);
    chk("midrst_ctrl", {fpu_reset_n, res_valid, busy, in_ready}, 64'b0001);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (200) begin @(posedge clk); #1; if (res_valid) seen++; end
    chk("no_ghost", seen, 0);
    chk("idle_after_rst", {busy, in_ready}, 2'b01);
    push(32'h40000000, 32'h40000000, {32'h42000000, EXACT});
    wait_res(n);
    chk("lat_after_rst", n, 74);
    chk("cnt_after_rst", op_count, 16'd1);
    @(posedge clk); #1;

    // op_count wrap.
    @(negedge clk);
    force dut.op_count = 16'hFFFF;
    @(negedge clk);
    release dut.op_count;
    chk("preload", op_count, 16'hFFFF);
    push(32'h40000000, 32'hC0000000, {32'h00000000, EXACT});
    wait_res(n);
    chk("wrap", op_count, 16'h0000);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
